panel_step_repeater: RTL and testbench

- Front-panel STEP switch conditioner: synchronises and debounces the raw active-low switch, then produces active-low single-clock step pulses.
- Emits one pulse on press. If the switch is held, emits repeat pulses after an initial hold delay, then at a fixed repeat rate.
- Sits between the panel switch and the step/clock-gating logic. Its nstep_pulse feeds the downstream NAND clock gate as the active-low "pulse" term.

---
 rtl/panel_pkg.sv | 23 ++
 rtl/panel_debounce.sv | 55 +++++
 rtl/panel_step_repeater.sv | 107 ++++++++++
 tb/tb_panel_step_repeater.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel switch conditioners (STEP, RUN, STOP, DEPOSIT).
// Holds the step/repeat state type and the default timing constants.
package panel_pkg;

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        HOLD    = 2'd2,
        REPEAT  = 2'd3
    } step_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES     = 1000;
    localparam int DEF_REPEAT_CYCLES   = 200;
    localparam int DEF_CW              = 16;

    localparam int SYNC_STAGES = 2;
    // Released-and-settled cycles needed to leave LOCKOUT. One more than the
    // synchroniser depth, so the reset value still sitting in the synchroniser
    // cannot masquerade as a release.
    localparam int LOCKOUT_QUIET_CYCLES = SYNC_STAGES + 1;

endpackage

// File: rtl/panel_debounce.sv
// Two-flop synchroniser plus debounce counter for one active-low panel switch.
// pressed changes on the edge that completes DEBOUNCE_CYCLES stable differing samples.
module panel_debounce
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CW              = DEF_CW
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_nsw,
    output logic o_pressed,
    output logic o_quiet
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sn;
    logic          r_pressed;
    logic [CW-1:0] r_cnt;
    logic          w_differs;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync1 <= 1'b1;
            r_sn    <= 1'b1;
        end else begin
            r_sync1 <= i_nsw;
            r_sn    <= r_sync1;
        end
    end

    // The debounced level is stored inverted as r_pressed, so acceptance and the
    // pressed output land on the same edge. Level = ~r_pressed.
    assign w_differs = (r_sn == r_pressed);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt     <= '0;
            r_pressed <= 1'b0;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_pressed <= ~r_sn;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_pressed = r_pressed;
    assign o_quiet   = r_sn & ~r_pressed;

endmodule

// File: rtl/panel_step_repeater.sv
// STEP switch conditioner: debounced press gives one active-low pulse, holding repeats.
// Press to pulse = 2 + DEBOUNCE_CYCLES + 1 cycles; then HOLD_CYCLES, then every REPEAT_CYCLES.
module panel_step_repeater
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CW              = DEF_CW
) (
    input  logic clk,
    input  logic nreset,
    input  logic nstep_sw,
    input  logic enable,
    output logic nstep_pulse,
    output logic pressed,
    output logic repeating
);

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_LOAD   = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] QUIET_LAST = CW'(LOCKOUT_QUIET_CYCLES - 1);

    step_state_e   r_state;
    step_state_e   w_state_nxt;
    logic [CW-1:0] r_tmr;
    logic [CW-1:0] w_tmr_nxt;
    logic [CW-1:0] w_tmr_dec;
    logic          w_pressed;
    logic          w_quiet;
    logic          w_fire;
    logic          r_pulse_n;
    logic          r_repeating;

    panel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CW             (CW)
    ) u_debounce (
        .clk      (clk),
        .nreset   (nreset),
        .i_nsw    (nstep_sw),
        .o_pressed(w_pressed),
        .o_quiet  (w_quiet)
    );

    assign w_tmr_dec = r_tmr - CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_fire      = 1'b0;
        case (r_state)
            // The timer doubles as the quiet-cycle counter while locked out.
            LOCKOUT: begin
                if (!w_quiet) begin
                    w_tmr_nxt = '0;
                end else if (r_tmr == QUIET_LAST) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + CW'(1);
                end
            end
            IDLE: begin
                if (w_pressed) begin
                    w_fire      = 1'b1;
                    w_tmr_nxt   = HOLD_LOAD;
                    w_state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!w_pressed) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_tmr_dec == '0) begin
                    w_fire      = 1'b1;
                    w_tmr_nxt   = REP_LOAD;
                    w_state_nxt = REPEAT;
                end else begin
                    w_tmr_nxt = w_tmr_dec;
                end
            end
            default: begin
                w_state_nxt = LOCKOUT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= LOCKOUT;
            r_tmr       <= '0;
            r_pulse_n   <= 1'b1;
            r_repeating <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_pulse_n   <= ~(w_fire & enable);
            r_repeating <= (w_state_nxt == REPEAT);
        end
    end

    assign nstep_pulse = r_pulse_n;
    assign pressed     = w_pressed;
    assign repeating   = r_repeating;

endmodule

// File: tb/tb_panel_step_repeater.sv
// Bench for panel_step_repeater: directed panel scenarios plus random switch activity,
// every cycle compared against a cycle-indexed behavioural model.
module tb_panel_step_repeater;

    localparam int D  = 4;
    localparam int H  = 20;
    localparam int R  = 5;
    localparam int CW = 16;

    typedef enum int {M_LOCK, M_IDLE, M_HOLD, M_REP} mode_e;

    logic clk = 1'b0;
    logic nreset;
    logic nstep_sw;
    logic enable;
    logic nstep_pulse;
    logic pressed;
    logic repeating;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    bit    sw_hist[$];
    bit    m_level;
    mode_e m_mode;
    int    m_quiet;
    int    m_next_fire;
    bit    m_pulse;
    int    tc;

    int sc;
    int pq[$];

    panel_step_repeater #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .CW             (CW)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .nstep_sw   (nstep_sw),
        .enable     (enable),
        .nstep_pulse(nstep_pulse),
        .pressed    (pressed),
        .repeating  (repeating)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // synchronised switch seen by the debouncer in cycle t (reset value before the pipe fills)
    function automatic bit sn_at(int t);
        if (t < 2) return 1'b1;
        return sw_hist[t-2];
    endfunction

    function automatic int pulse_at(int i);
        if (i < pq.size()) return pq[i];
        return -1;
    endfunction

    task automatic model_reset();
        sw_hist.delete();
        m_level     = 1'b1;
        m_mode      = M_LOCK;
        m_quiet     = 0;
        m_next_fire = 0;
        m_pulse     = 1'b0;
        tc          = 0;
    endtask

    // Decide cycle tc from its inputs, producing the expectations for cycle tc+1.
    task automatic model_advance(input bit en);
        bit prs;
        bit quiet;
        bit v;
        bit flip;
        prs     = !m_level;
        quiet   = sn_at(tc) && m_level;
        m_pulse = 1'b0;
        case (m_mode)
            M_LOCK: begin
                m_quiet = quiet ? m_quiet + 1 : 0;
                if (m_quiet == 3) begin
                    m_mode  = M_IDLE;
                    m_quiet = 0;
                end
            end
            M_IDLE: begin
                if (prs) begin
                    m_pulse     = en;
                    m_next_fire = tc + 1 + H;
                    m_mode      = M_HOLD;
                end
            end
            default: begin
                if (!prs) begin
                    m_mode = M_IDLE;
                end else if (tc + 1 == m_next_fire) begin
                    m_pulse     = en;
                    m_next_fire = m_next_fire + R;
                    m_mode      = M_REP;
                end
            end
        endcase
        // accept a new level once the last D synchronised samples all disagree with it
        v    = sn_at(tc);
        flip = (v != m_level);
        for (int k = tc - D + 1; k <= tc; k++)
            if (sn_at(k) != v) flip = 1'b0;
        if (flip) m_level = v;
        tc++;
    endtask

    task automatic step(input bit sw, input bit en);
        chk("nstep_pulse", nstep_pulse, !m_pulse);
        chk("pressed", pressed, !m_level);
        chk("repeating", repeating, m_mode == M_REP);
        if (!nstep_pulse) pq.push_back(sc);
        nstep_sw = sw;
        enable   = en;
        sw_hist.push_back(sw);
        model_advance(en);
        sc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit sw, input bit en, input int n);
        for (int i = 0; i < n; i++) step(sw, en);
    endtask

    task automatic async_reset(input bit sw);
        #2 nreset = 1'b0;
        #1;
        chk("arst_nstep_pulse", nstep_pulse, 1);
        chk("arst_pressed", pressed, 0);
        chk("arst_repeating", repeating, 0);
        nstep_sw = sw;
        enable   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 nreset = 1'b1;
        model_reset();
    endtask

    initial begin
        int n_early;
        int hold_exp[5];
        hold_exp = '{7, 27, 32, 37, 42};
        nreset   = 1'b1;
        nstep_sw = 1'b1;
        enable   = 1'b1;
        sc       = 0;
        #1;
        async_reset(1'b1);
        run(1, 1, 15);

        // single tap
        sc = 0; pq.delete();
        run(0, 1, 10); run(1, 1, 30);
        chk("tap_count", pq.size(), 1);
        chk("tap_cycle", pulse_at(0), 7);

        // hold with repeats
        sc = 0; pq.delete();
        run(0, 1, 40); run(1, 1, 20);
        chk("hold_count", pq.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("hold_pulse%0d", i), pulse_at(i), hold_exp[i]);

        // bounce shorter than the debounce window
        sc = 0; pq.delete();
        for (int i = 0; i < 4; i++) begin
            run(0, 1, 2); run(1, 1, 1);
        end
        run(1, 1, 20);
        chk("bounce_count", pq.size(), 0);

        // enable gating mid-hold keeps the schedule
        sc = 0; pq.delete();
        run(0, 1, 25); run(0, 0, 10); run(0, 1, 5); run(1, 1, 20);
        n_early = 0;
        foreach (pq[i]) if (pq[i] <= 40) n_early++;
        chk("gate_count", n_early, 2);
        chk("gate_first", pulse_at(0), 7);
        chk("gate_second", pulse_at(1), 37);

        // switch held through reset release
        async_reset(1'b0);
        sc = 0; pq.delete();
        run(0, 1, 50); run(1, 1, 10);
        chk("stuck_count", pq.size(), 0);
        sc = 0; pq.delete();
        run(0, 1, 10); run(1, 1, 20);
        chk("stuck_repress", pulse_at(0), 7);

        // reset while a repeat pulse is low
        sc = 0; pq.delete();
        run(0, 1, 32);
        chk("pre_rst_pulse", nstep_pulse, 0);
        chk("pre_rst_repeating", repeating, 1);
        async_reset(1'b0);
        sc = 0; pq.delete();
        run(0, 1, 30); run(1, 1, 12);
        chk("post_rst_count", pq.size(), 0);
        sc = 0; pq.delete();
        run(0, 1, 10); run(1, 1, 20);
        chk("post_rst_press", pulse_at(0), 7);

        // random switch activity with occasional enable drops
        for (int seg = 0; seg < 120; seg++) begin
            bit sw;
            bit en;
            int len;
            sw  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 7) != 0);
            len = (seg % 3 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
            run(sw, en, len);
        end
        run(1, 1, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
